// File: rtl/gpio_pad_arbiter.sv
// Round-robin owner arbitration for a shared GPIO pad bank.
// One requester owns the whole bank at a time. Every hand-over passes through
// a turnaround window with all output enables low, so two drivers never
// overlap on the pads. An optional hold limit lets a waiting requester
// preempt an owner that keeps the bank too long.
module gpio_pad_arbiter #(
  parameter int GpioCount  = 32,
  parameter int NumReq     = 2,
  parameter int TurnCycles = 2,
  parameter int MaxHold    = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NumReq-1:0]             req_i,
  output logic [NumReq-1:0]             gnt_o,
  input  logic [NumReq*GpioCount-1:0]   req_gpio_o_i,
  input  logic [NumReq*GpioCount-1:0]   req_gpio_out_en_i,
  output logic [GpioCount-1:0]          gpio_i_o,
  input  logic [GpioCount-1:0]          pad_gpio_i,
  output logic [GpioCount-1:0]          pad_gpio_o,
  output logic [GpioCount-1:0]          pad_gpio_out_en_o,
  output logic                          preempt_o,
  output logic                          busy_o
);

  localparam int IdxW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int HoldW = (MaxHold > 0) ? $clog2(MaxHold + 1) : 1;
  localparam int TurnW = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN  = 2'd1,
    ST_TURN = 2'd2
  } state_e;

  state_e            state_r, state_s;
  logic [NumReq-1:0] gnt_r, gnt_s;
  logic [IdxW-1:0]   owner_r, owner_s;
  logic [IdxW-1:0]   rr_r, rr_s;
  logic [HoldW-1:0]  hold_r, hold_s;
  logic [TurnW-1:0]  turn_r, turn_s;
  logic              preempt_r, preempt_s;
  logic              busy_r, busy_s;

  logic              win_found_s;
  logic [IdxW-1:0]   win_idx_s;
  logic              others_req_s;
  logic              preempt_hit_s;
  logic [GpioCount-1:0] pad_o_s;
  logic [GpioCount-1:0] pad_en_s;

  // Round-robin successor of a requester index, wrapping at NumReq.
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx);
    if (idx == IdxW'(NumReq - 1)) begin
      return '0;
    end else begin
      return idx + IdxW'(1);
    end
  endfunction

  // Pad inputs are broadcast to every requester regardless of ownership.
  assign gpio_i_o = pad_gpio_i;

  // Pick the first active request at or above the round-robin pointer, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    for (int i = 0; i < NumReq; i++) begin
      int cand;
      cand = (int'(rr_r) + i) % NumReq;
      if (!win_found_s && req_i[cand]) begin
        win_found_s = 1'b1;
        win_idx_s   = IdxW'(cand);
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Preemption fires on the last allowed ownership cycle when someone else waits.
  always_comb begin
    others_req_s  = |(req_i & ~gnt_r);
    preempt_hit_s = (MaxHold > 0) && (hold_r == HoldW'(MaxHold - 1)) && others_req_s;
  end

  // Next-state and next-output logic for the IDLE/OWN/TURN controller.
  always_comb begin
    state_s   = state_r;
    gnt_s     = gnt_r;
    owner_s   = owner_r;
    rr_s      = rr_r;
    hold_s    = hold_r;
    turn_s    = turn_r;
    preempt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_s            = ST_OWN;
          gnt_s              = '0;
          gnt_s[win_idx_s]   = 1'b1;
          owner_s            = win_idx_s;
          hold_s             = '0;
        end else begin
          gnt_s = '0;
        end
      end
      ST_OWN: begin
        if (!req_i[owner_r]) begin
          // Voluntary release takes precedence over a coincident preemption.
          state_s = ST_TURN;
          gnt_s   = '0;
          turn_s  = '0;
          rr_s    = next_idx(owner_r);
        end else if (preempt_hit_s) begin
          state_s   = ST_TURN;
          gnt_s     = '0;
          turn_s    = '0;
          rr_s      = next_idx(owner_r);
          preempt_s = 1'b1;
        end else if (hold_r != HoldW'(MaxHold)) begin
          hold_s = hold_r + HoldW'(1);
        end else begin
          hold_s = hold_r;
        end
      end
      ST_TURN: begin
        if (turn_r == TurnW'(TurnCycles - 1)) begin
          state_s = ST_IDLE;
          turn_s  = '0;
        end else begin
          turn_s = turn_r + TurnW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = '0;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // Controller state and registered outputs, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      gnt_r     <= '0;
      owner_r   <= '0;
      rr_r      <= '0;
      hold_r    <= '0;
      turn_r    <= '0;
      preempt_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      gnt_r     <= gnt_s;
      owner_r   <= owner_s;
      rr_r      <= rr_s;
      hold_r    <= hold_s;
      turn_r    <= turn_s;
      preempt_r <= preempt_s;
      busy_r    <= busy_s;
    end
  end

  // Drive the pads from the granted slice only; no grant means all-input.
  always_comb begin
    pad_o_s  = '0;
    pad_en_s = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (gnt_r[k]) begin
        pad_o_s  = pad_o_s  | req_gpio_o_i[k*GpioCount +: GpioCount];
        pad_en_s = pad_en_s | req_gpio_out_en_i[k*GpioCount +: GpioCount];
      end else begin
        pad_o_s  = pad_o_s;
        pad_en_s = pad_en_s;
      end
    end
  end

  assign gnt_o             = gnt_r;
  assign preempt_o         = preempt_r;
  assign busy_o            = busy_r;
  assign pad_gpio_o        = pad_o_s;
  assign pad_gpio_out_en_o = pad_en_s;

endmodule

// File: tb/tb_gpio_pad_arbiter.sv
// Directed bench for gpio_pad_arbiter with an ownership-level reference model.
module tb_gpio_pad_arbiter;

  localparam int GC = 32;
  localparam int NR = 2;
  localparam int TC = 2;
  localparam int MH = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [NR-1:0]    req_i;
  logic [NR-1:0]    gnt_o;
  logic [NR*GC-1:0] req_gpio_o_i;
  logic [NR*GC-1:0] req_gpio_out_en_i;
  logic [GC-1:0]    gpio_i_o;
  logic [GC-1:0]    pad_gpio_i;
  logic [GC-1:0]    pad_gpio_o;
  logic [GC-1:0]    pad_gpio_out_en_o;
  logic             preempt_o;
  logic             busy_o;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  gpio_pad_arbiter #(
    .GpioCount(GC), .NumReq(NR), .TurnCycles(TC), .MaxHold(MH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .gnt_o(gnt_o),
    .req_gpio_o_i(req_gpio_o_i), .req_gpio_out_en_i(req_gpio_out_en_i),
    .gpio_i_o(gpio_i_o), .pad_gpio_i(pad_gpio_i), .pad_gpio_o(pad_gpio_o),
    .pad_gpio_out_en_o(pad_gpio_out_en_o), .preempt_o(preempt_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference model: who owns the bank, turnaround cycles left, owned-cycle count.
  int m_owner = -1;
  int m_turn  = 0;
  int m_held  = 0;
  int m_rr    = 0;
  bit m_pre   = 1'b0;

  function automatic int pick(input logic [NR-1:0] req, input int rr);
    for (int i = 0; i < NR; i++) begin
      if (req[(rr + i) % NR]) return (rr + i) % NR;
    end
    return -1;
  endfunction

  function automatic bit others_waiting(input logic [NR-1:0] req, input int owner);
    for (int i = 0; i < NR; i++) begin
      if (i != owner && req[i]) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Advance the model on each clock edge using the inputs the DUT samples.
  always @(posedge clk_i) begin
    if (rst_i) begin
      m_owner <= -1; m_turn <= 0; m_held <= 0; m_rr <= 0; m_pre <= 1'b0;
    end else if (m_owner >= 0) begin
      if (!req_i[m_owner]) begin
        m_owner <= -1; m_turn <= TC; m_rr <= (m_owner + 1) % NR; m_held <= 0; m_pre <= 1'b0;
      end else if (MH > 0 && m_held == MH - 1 && others_waiting(req_i, m_owner)) begin
        m_owner <= -1; m_turn <= TC; m_rr <= (m_owner + 1) % NR; m_held <= 0; m_pre <= 1'b1;
      end else begin
        m_held <= m_held + 1; m_pre <= 1'b0;
      end
    end else if (m_turn > 0) begin
      m_turn <= m_turn - 1; m_pre <= 1'b0;
    end else begin
      m_pre <= 1'b0;
      if (req_i != '0) begin
        m_owner <= pick(req_i, m_rr);
        m_held  <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [GC-1:0] act, input logic [GC-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model mid-cycle.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      chk("gnt",     GC'(gnt_o),   (m_owner >= 0) ? GC'(1) << m_owner : '0);
      chk("pad_o",   pad_gpio_o,   (m_owner >= 0) ? req_gpio_o_i[m_owner*GC +: GC] : '0);
      chk("pad_en",  pad_gpio_out_en_o, (m_owner >= 0) ? req_gpio_out_en_i[m_owner*GC +: GC] : '0);
      chk("busy",    GC'(busy_o),  GC'((m_owner >= 0) || (m_turn > 0)));
      chk("preempt", GC'(preempt_o), GC'(m_pre));
      chk("gpio_i",  gpio_i_o,     pad_gpio_i);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset(input int n);
    rst_i = 1'b1;
    req_i = 2'b00;
    repeat (n) step();
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i             = 1'b1;
    req_i             = 2'b11;
    pad_gpio_i        = 32'h1234_5678;
    req_gpio_o_i      = {32'hDEAD_BEEF, 32'hA5A5_0001};
    req_gpio_out_en_i = {32'h0000_FFFF, 32'hFFFF_0000};

    // Reset held three cycles with both requests high.
    for (int c = 0; c < 3; c++) begin
      step();
      cmp_en = 1'b1;
      chk("rst_gnt",  GC'(gnt_o), 32'h0);
      chk("rst_en",   pad_gpio_out_en_o, 32'h0);
      chk("rst_busy", GC'(busy_o), 32'h0);
      chk("rst_gpio_i", gpio_i_o, 32'h1234_5678);
    end
    rst_i = 1'b0;
    req_i = 2'b00;
    step();

    // Single owner, then release and turnaround.
    do_reset(1);
    req_i = 2'b01;
    step();                                   // cycle 1
    chk("s1_gnt", GC'(gnt_o), 32'h1);
    chk("s1_pad", pad_gpio_o, 32'hA5A5_0001);
    chk("s1_en",  pad_gpio_out_en_o, 32'hFFFF_0000);
    repeat (9) step();                        // cycle 10
    req_i = 2'b00;
    step();                                   // cycle 11
    chk("s1_t11_gnt", GC'(gnt_o), 32'h0);
    chk("s1_t11_en",  pad_gpio_out_en_o, 32'h0);
    chk("s1_t11_busy", GC'(busy_o), 32'h1);
    step();                                   // cycle 12
    chk("s1_t12_en",  pad_gpio_out_en_o, 32'h0);
    chk("s1_t12_busy", GC'(busy_o), 32'h1);
    step();                                   // cycle 13
    chk("s1_idle_busy", GC'(busy_o), 32'h0);

    // Fairness: req0 first, req1 at release+4, then alternation by preemption.
    do_reset(1);
    req_i = 2'b11;
    step();                                   // cycle 1
    chk("f_gnt1", GC'(gnt_o), 32'h1);
    repeat (3) step();                        // cycle 4
    req_i = 2'b10;
    repeat (3) step();                        // cycle 7
    chk("f_gnt7", GC'(gnt_o), 32'h0);
    step();                                   // cycle 8
    chk("f_gnt8", GC'(gnt_o), 32'h2);
    chk("f_pad8", pad_gpio_o, 32'hDEAD_BEEF);
    chk("f_en8",  pad_gpio_out_en_o, 32'h0000_FFFF);
    req_i = 2'b11;
    repeat (8) step();                        // cycle 16
    chk("f_pre16", GC'(preempt_o), 32'h1);
    repeat (3) step();                        // cycle 19
    chk("f_gnt19", GC'(gnt_o), 32'h1);
    repeat (11) step();                       // cycle 30
    chk("f_gnt30", GC'(gnt_o), 32'h2);
    repeat (11) step();                       // cycle 41
    chk("f_gnt41", GC'(gnt_o), 32'h1);
    req_i = 2'b00;
    repeat (4) step();

    // Preemption of req0 by req1, then req0 regranted after req1 releases.
    do_reset(1);
    req_i = 2'b01;
    step();                                   // cycle 1
    chk("p_gnt1", GC'(gnt_o), 32'h1);
    step();                                   // cycle 2
    req_i = 2'b11;
    repeat (6) step();                        // cycle 8
    chk("p_pre8", GC'(preempt_o), 32'h0);
    step();                                   // cycle 9
    chk("p_gnt9", GC'(gnt_o), 32'h0);
    chk("p_pre9", GC'(preempt_o), 32'h1);
    step();                                   // cycle 10
    chk("p_pre10", GC'(preempt_o), 32'h0);
    chk("p_busy10", GC'(busy_o), 32'h1);
    step();                                   // cycle 11
    chk("p_busy11", GC'(busy_o), 32'h0);
    step();                                   // cycle 12
    chk("p_gnt12", GC'(gnt_o), 32'h2);
    repeat (2) step();                        // cycle 14
    req_i = 2'b01;
    repeat (3) step();                        // cycle 17
    chk("p_gnt17", GC'(gnt_o), 32'h0);
    step();                                   // cycle 18
    chk("p_gnt18", GC'(gnt_o), 32'h1);
    req_i = 2'b00;
    repeat (4) step();

    // Reset while req0 owns.
    do_reset(1);
    req_i = 2'b11;
    step();                                   // cycle 1
    chk("r_gnt1", GC'(gnt_o), 32'h1);
    repeat (4) step();                        // cycle 5
    rst_i = 1'b1;
    step();                                   // cycle 6
    chk("r_gnt6", GC'(gnt_o), 32'h0);
    chk("r_en6",  pad_gpio_out_en_o, 32'h0);
    chk("r_busy6", GC'(busy_o), 32'h0);
    chk("r_pre6", GC'(preempt_o), 32'h0);
    rst_i = 1'b0;
    step();                                   // cycle 7
    chk("r_gnt7", GC'(gnt_o), 32'h1);
    req_i = 2'b00;
    repeat (4) step();

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
